// File: rtl/bennett_phase_capture.sv
// Captures the adiabatic logic output once per Bennett instruction on the settled
// plateau of one clock phase, buffers it in a FWFT FIFO, and flags phase mis-sequencing.
module bennett_phase_capture #(
    parameter int unsigned PHASES    = 10,
    parameter int unsigned CAP_PHASE = 4,
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned SETTLE    = 1,
    parameter int unsigned DEPTH     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PHASES-1:0] clkp,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              seq_err,
    output logic [15:0]       cap_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SW-1:0]     cnt;
    logic [SW-1:0]     cnt_next;
    logic              sample;
    logic              plateau_err;

    logic [PHASES-1:0] clkp_q;
    logic [PHASES-1:0] rise;
    logic [PHASES-1:0] fall;
    logic [PHASES-1:0] prev_hi;
    logic [PHASES-1:0] next_lo;
    logic              order_err;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_after_pop;
    logic [CW-1:0]     count_next;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic [WIDTH-1:0]  head_next;

    assign rise = clkp & ~clkp_q;
    assign fall = ~clkp & clkp_q;

    // Neighbour views: bit k sees phase k-1 (prev_hi) or k+1 (next_lo); end phases are unconstrained.
    assign prev_hi   = {clkp_q[PHASES-2:0], 1'b1};
    assign next_lo   = {1'b0, clkp_q[PHASES-1:1]};
    assign order_err = (|(rise & ~prev_hi)) | (|(fall & next_lo));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        sample      = 1'b0;
        plateau_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise[CAP_PHASE]) begin
                    if (SETTLE == 0) begin
                        sample     = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        cnt_next   = SW'(SETTLE - 1);
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Phase dropped before settling: the sample would be meaningless.
                if (!clkp[CAP_PHASE]) begin
                    plateau_err = 1'b1;
                    state_next  = ST_IDLE;
                end else if (cnt == '0) begin
                    sample     = 1'b1;
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt - SW'(1);
                end
            end
            ST_HOLD: begin
                if (fall[CAP_PHASE]) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        full            = (count == CW'(DEPTH));
        pop             = out_valid & out_ready;
        push            = sample & (~full | pop);
        drop            = sample & full & ~pop;
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        rd_ptr_next     = rd_ptr + AW'(pop);
        // Head register tracks the word at the post-update read pointer.
        if (count_after_pop == '0) begin
            head_next = push ? data_in : out_data;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clkp_q    <= clkp;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            seq_err   <= 1'b0;
            cap_count <= '0;
        end else begin
            clkp_q    <= clkp;
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            out_data  <= head_next;
            overflow  <= overflow | drop;
            seq_err   <= seq_err | order_err | plateau_err;
            cap_count <= cap_count + 16'(push);
        end
    end

endmodule

// File: doc/bennett_phase_capture.md
# bennett_phase_capture

Response-side capture block for adiabatic SRAM-bank test benches and on-chip checkers. It watches the Bennett clock phase bus, samples the adiabatic logic output once per instruction while the selected phase is held high and settled, and buffers the captured words in a small first-word-fall-through FIFO drained by a valid/ready reader. It also checks the Bennett ramp ordering and flags violations, so a bench can detect mis-sequenced phases as well as wrong data.

## Interface
- `PHASES`, 10: width of the phase bus from `bennett_clock`.
- `CAP_PHASE`, 4: index of the phase whose high plateau is sampled (0..PHASES-1).
- `WIDTH`, 1: captured data width.
- `SETTLE`, 1: clk cycles after the detected rise before sampling (0..15).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).

Ports:
- `clk` in 1: system clock, same clock that drives `bennett_clock`.
- `reset` in 1: synchronous, active-high reset.
- `clkp` in PHASES: phase bus, generated in the `clk` domain; no synchronizer.
- `data_in` in WIDTH: adiabatic logic output to sample.
- `out_data` out WIDTH: FIFO head word.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: reader accepts the head word this cycle.
- `overflow` out 1: sticky; a capture was dropped because the FIFO was full.
- `seq_err` out 1: sticky; a phase ordering or plateau violation occurred.
- `cap_count` out 16: number of captures accepted into the FIFO, wraps at 2^16.

## Operation
- Register `clkp_q` holds the previous `clkp`. `rise[k] = clkp[k] & ~clkp_q[k]` and `fall[k] = ~clkp[k] & clkp_q[k]`.
- During `reset`, `clkp_q` loads `clkp`. This prevents a spurious edge on the first cycle after reset.
- Capture FSM:
  - IDLE:
    - `rise[CAP_PHASE]` with SETTLE=0 goes to CAPTURE-in-place: it samples on the same edge and moves to HOLD.
    - `rise[CAP_PHASE]` with SETTLE>0 loads counter=SETTLE-1 and moves to WAIT.
  - WAIT:
    - Counter decrements each cycle; at 0 it samples `data_in` and moves to HOLD.
    - `fall[CAP_PHASE]` or `clkp[CAP_PHASE]==0` in WAIT sets `seq_err`, drops the sample and returns to IDLE.
  - HOLD: waits for `fall[CAP_PHASE]`, then goes to IDLE. A `rise[CAP_PHASE]` in HOLD is impossible and is ignored.
- Sampling pushes `data_in` into the FIFO:
  - If the FIFO is full and no pop happens this cycle, the word is dropped and `overflow` is set.
  - Otherwise the word is written and `cap_count` increments.
- Pop: `out_valid & out_ready` advances the read pointer. `out_data` always shows the head word (first-word fall-through).
- Push and pop in the same cycle:
  - When full, both succeed and the occupancy stays at DEPTH.
  - When empty, the push succeeds and the pop is a no-op because `out_valid` is 0.
- Ordering check, evaluated every cycle for all k; any violation sets `seq_err`:
  - `rise[k]` with k>0 requires `clkp_q[k-1]==1`.
  - `fall[k]` with k<PHASES-1 requires `clkp_q[k+1]==0`.
- Occupancy counter is log2(DEPTH)+1 bits. Pointers are log2(DEPTH) bits and wrap naturally.
- `overflow` and `seq_err` clear only on `reset`.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `overflow`=0, `seq_err`=0, `cap_count`=0.
  - FSM in IDLE, FIFO empty.
- `reset` asserted mid-capture: the next edge forces IDLE, empties the FIFO and discards any in-flight sample.
- With `rise[CAP_PHASE]` detected at edge N:
  - `data_in` is sampled at edge N+SETTLE.
  - `out_valid` rises after edge N+SETTLE if the FIFO was empty.
  - `cap_count` updates on the same edge.
- Pop at edge M: the next word, or `out_valid`=0, is visible after edge M.
- Sticky flags assert on the edge where the violation is detected.

## Test plan
- Drive `bennett_clock`, PHASES=10, CAP_PHASE=4, SETTLE=1, with `data_in` following an inverter of the vector 0,0,1 applied on `clkp[2]` rises. Required response: FIFO reads 1,1,0 in order, `cap_count`=3, `seq_err`=0.
- `out_ready`=0, DEPTH=4, 6 instructions. Required response: 4 words held, `overflow`=1 after the 5th capture, `cap_count`=4. Then drain and confirm the first 4 values are intact.
- FIFO full, with `out_ready`=1 on the cycle of the 5th capture. Required response: no overflow, `cap_count`=5, head advances by one.
- Force `clkp[5]` to rise while `clkp[4]`=0. Required response: `seq_err`=1 the next cycle and stays 1; data capture is unaffected.
- SETTLE=3, with `clkp[4]` pulsed high for 2 cycles only. Required response: no push, `seq_err`=1, FSM returns to IDLE.
- Assert `reset` during WAIT with 2 words buffered, with `clkp` high at reset release. Required response: `out_valid`=0, `cap_count`=0, no spurious capture after release.
